// File: rtl/rv32i_text_blitter_pkg.sv
// ============================================================================
//  Module   : rv32i_text_blitter_pkg
//  Purpose  : Shared constants, FSM encoding and character remap helper for
//             the text blitter and its column serializer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_text_blitter_pkg;

    localparam logic [19:0] FONT_BASE_HI = 20'hE0001;
    localparam int          GLYPH_W      = 12;
    localparam int          GLYPH_H      = 16;
    localparam logic [6:0]  SPACE_CHAR   = 7'd32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Control codes have no glyphs; they render as a blank cell.
    function automatic logic [6:0] remap_char(input logic [6:0] ch);
        return (ch < SPACE_CHAR) ? SPACE_CHAR : ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_blit_colser.sv
// ============================================================================
//  Module   : rv32i_blit_colser
//  Purpose  : Serializes one 16-bit font column into 16 row pixels under
//             valid/ready, flagging the final row transfer.
//             Option macro: TEXT_TRANSPARENT_BG_EN (skip background pixels).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_blit_colser #(
    parameter int COLOR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [15:0]        load_data,
    input  logic [COLOR_W-1:0] fg,
    input  logic [COLOR_W-1:0] bg,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [3:0]         pix_row,
    output logic [COLOR_W-1:0] pix_data,
    output logic               last
);

    logic        active_q, active_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  row_q, row_d;
    logic        w_bit;
    logic        w_advance;

    // Column is shifted left so the current row's bit is always at [15].
    assign w_bit    = shreg_q[15];
    assign pix_row  = row_q;
    assign pix_data = w_bit ? fg : bg;

`ifdef TEXT_TRANSPARENT_BG_EN
    assign pix_valid = active_q & w_bit;
    assign w_advance = active_q & (pix_ready | ~w_bit);
`else
    assign pix_valid = active_q;
    assign w_advance = active_q & pix_ready;
`endif

    assign last = w_advance & (row_q == 4'd15);

    always_comb begin
        active_d = active_q;
        shreg_d  = shreg_q;
        row_d    = row_q;
        if (load) begin
            active_d = 1'b1;
            shreg_d  = load_data;
            row_d    = 4'd0;
        end else if (w_advance) begin
            shreg_d = {shreg_q[14:0], 1'b0};
            row_d   = row_q + 4'd1;
            if (row_q == 4'd15) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            shreg_q  <= 16'd0;
            row_q    <= 4'd0;
        end else begin
            active_q <= active_d;
            shreg_q  <= shreg_d;
            row_q    <= row_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32i_text_blitter.sv
// ============================================================================
//  Module   : rv32i_text_blitter
//  Purpose  : Draws one 12x16 glyph per command: fetches font columns from
//             the ROM and streams pixel writes to the framebuffer.
//             Option macro: TEXT_TRANSPARENT_BG_EN (skip background pixels).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_text_blitter
    import rv32i_text_blitter_pkg::*;
#(
    parameter int COLS    = 26,
    parameter int ROWS    = 15,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [6:0]         cmd_char,
    input  logic [4:0]         cmd_x,
    input  logic [3:0]         cmd_y,
    input  logic [COLOR_W-1:0] cmd_fg,
    input  logic [COLOR_W-1:0] cmd_bg,
    output logic               font_cs,
    output logic               font_we,
    output logic [31:0]        font_addr,
    input  logic [31:0]        font_data,
    output logic               fb_valid,
    input  logic               fb_ready,
    output logic [X_W-1:0]     fb_x,
    output logic [Y_W-1:0]     fb_y,
    output logic [COLOR_W-1:0] fb_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             state_q, state_d;
    logic [6:0]         char_q, char_d;
    logic [4:0]         x_q, x_d;
    logic [3:0]         y_q, y_d;
    logic [COLOR_W-1:0] fg_q, fg_d;
    logic [COLOR_W-1:0] bg_q, bg_d;
    logic [3:0]         col_q, col_d;
    logic [31:0]        font_addr_q, font_addr_d;
    logic               err_q, err_d;

    logic               w_in_range;
    logic               w_load;
    logic               w_last;
    logic [3:0]         w_pix_row;
    logic [X_W-1:0]     w_x0;
    logic               w_unused_font_hi;

    assign w_unused_font_hi = ^font_data[31:16];

    assign w_in_range = (32'(cmd_x) < COLS) && (32'(cmd_y) < ROWS);
    assign w_load     = (state_q == WAIT);

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign font_cs   = (state_q == FETCH);
    assign font_we   = 1'b0;
    assign font_addr = font_addr_q;

    assign w_x0 = X_W'(x_q) * X_W'(GLYPH_W);
    assign fb_x = w_x0 + X_W'(col_q);
    assign fb_y = Y_W'({y_q, 4'b0000}) + Y_W'(w_pix_row);

    always_comb begin
        state_d     = state_q;
        char_d      = char_q;
        x_d         = x_q;
        y_d         = y_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        col_d       = col_q;
        font_addr_d = font_addr_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (w_in_range) begin
                        char_d      = remap_char(cmd_char);
                        x_d         = cmd_x;
                        y_d         = cmd_y;
                        fg_d        = cmd_fg;
                        bg_d        = cmd_bg;
                        col_d       = 4'd0;
                        font_addr_d = {FONT_BASE_HI, remap_char(cmd_char), 4'd0, 1'b0};
                        state_d     = FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH: state_d = WAIT;
            WAIT:  state_d = DRAW;
            DRAW: begin
                if (w_last) begin
                    if (col_q == 4'(GLYPH_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        col_d       = col_q + 4'd1;
                        font_addr_d = {FONT_BASE_HI, char_q, col_q + 4'd1, 1'b0};
                        state_d     = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            char_q      <= 7'd0;
            x_q         <= 5'd0;
            y_q         <= 4'd0;
            fg_q        <= '0;
            bg_q        <= '0;
            col_q       <= 4'd0;
            font_addr_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            char_q      <= char_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            col_q       <= col_d;
            font_addr_q <= font_addr_d;
            err_q       <= err_d;
        end
    end

    rv32i_blit_colser #(
        .COLOR_W (COLOR_W)
    ) u_colser (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_data (font_data[15:0]),
        .fg        (fg_q),
        .bg        (bg_q),
        .pix_ready (fb_ready),
        .pix_valid (fb_valid),
        .pix_row   (w_pix_row),
        .pix_data  (fb_data),
        .last      (w_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_rv32i_text_blitter.sv
// ============================================================================
//  Module   : tb_rv32i_text_blitter
//  Purpose  : Self-checking bench for rv32i_text_blitter with a font ROM model
//             and a per-pixel reference of every glyph drawn.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_text_blitter;

    typedef struct {
        logic [6:0]  ch;
        logic [4:0]  x;
        logic [3:0]  y;
        logic [15:0] fg;
        logic [15:0] bg;
        int          mode;       // 0: ready=1, 1: toggle, 2: random
        int          abort_at;   // 0: none
        int          exp_writes; // -1: taken from the model
    } vec_t;

    typedef struct {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [15:0] d;
    } pix_t;

`ifdef TEXT_TRANSPARENT_BG_EN
    localparam int W_ONE   = 20;
    localparam int W_BLANK = 0;
`else
    localparam int W_ONE   = 192;
    localparam int W_BLANK = 192;
`endif

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_char;
    logic [4:0]  cmd_x;
    logic [3:0]  cmd_y;
    logic [15:0] cmd_fg;
    logic [15:0] cmd_bg;
    logic        font_cs;
    logic        font_we;
    logic [31:0] font_addr;
    logic [31:0] font_data;
    logic        fb_valid;
    logic        fb_ready;
    logic [8:0]  fb_x;
    logic [7:0]  fb_y;
    logic [15:0] fb_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    rv32i_text_blitter dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_char  (cmd_char),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_fg    (cmd_fg),
        .cmd_bg    (cmd_bg),
        .font_cs   (font_cs),
        .font_we   (font_we),
        .font_addr (font_addr),
        .font_data (font_data),
        .fb_valid  (fb_valid),
        .fb_ready  (fb_ready),
        .fb_x      (fb_x),
        .fb_y      (fb_y),
        .fb_data   (fb_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Font contents: '1' is hand-drawn, space is blank, the rest pseudo-random.
    function automatic logic [15:0] glyph(input logic [6:0] ch, input int c);
        if (ch == 7'd32) return 16'h0000;
        if (ch == 7'h31) begin
            case (c)
                3:       return 16'h1004;
                4:       return 16'h2004;
                5:       return 16'h7FFC;
                6, 7, 8: return 16'h0004;
                default: return 16'h0000;
            endcase
        end
        return (16'(ch) * 16'd40503) ^ (16'(c) * 16'd29243) ^ 16'hA5C3;
    endfunction

    // Registered ROM: data appears the cycle after chip select; junk otherwise.
    always @(posedge clk) begin
        if (font_cs) begin
            if (font_addr[31:12] == 20'hE0001 && !font_addr[0] && font_addr[4:1] < 4'd12)
                font_data <= {16'($urandom), glyph(font_addr[11:5], int'(font_addr[4:1]))};
            else
                font_data <= 32'hDEAD_BEEF;
        end else begin
            font_data <= $urandom;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_case(input vec_t v);
        pix_t       q[$];
        logic [6:0] rc;
        logic [15:0] g;
        logic       b;
        logic       bad;
        logic       aborted;
        int         n, stalls, fetches, done_n, writes;

        rc      = (v.ch < 7'd32) ? 7'd32 : v.ch;
        bad     = (v.x >= 5'd26) || (v.y >= 4'd15);
        aborted = 1'b0;
        if (!bad) begin
            for (int c = 0; c < 12; c++) begin
                g = glyph(rc, c);
                for (int r = 0; r < 16; r++) begin
                    b = g[15-r];
`ifdef TEXT_TRANSPARENT_BG_EN
                    if (b)
`endif
                    q.push_back('{9'(int'(v.x) * 12 + c), 8'(int'(v.y) * 16 + r),
                                  b ? v.fg : v.bg});
                end
            end
        end

        @(posedge clk);
        #1;
        cmd_char  = v.ch;
        cmd_x     = v.x;
        cmd_y     = v.y;
        cmd_fg    = v.fg;
        cmd_bg    = v.bg;
        cmd_valid = 1'b1;
        fb_ready  = 1'b1;
        chk("cmd_ready_pre", 32'(cmd_ready), 32'd1);
        @(posedge clk);

        n = 0; stalls = 0; fetches = 0; done_n = 0; writes = 0;
        while (n < 3000 && done_n == 0) begin
            #1;
            if (n == 0) begin
                cmd_valid = 1'b0;
                cmd_char  = 7'($urandom);
                cmd_x     = 5'($urandom);
                cmd_y     = 4'($urandom);
                cmd_fg    = 16'($urandom);
                cmd_bg    = 16'($urandom);
            end
            if (v.abort_at != 0 && n == v.abort_at) begin
                chk("abort_col", 32'(fetches), 32'd7);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk("abort_ready", 32'(cmd_ready), 32'd1);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_valid", 32'(fb_valid), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("abort_no_done", {busy, done, font_cs}, 32'd0);
                end
                aborted = 1'b1;
                break;
            end
            case (v.mode)
                1:       fb_ready = ((n + 1) % 2) == 1;
                2:       fb_ready = ($urandom_range(0, 3) != 0);
                default: fb_ready = 1'b1;
            endcase
            n++;
            @(negedge clk);
            if (bad) begin
                chk("err_pulse", 32'(err), (n == 1) ? 32'd1 : 32'd0);
                chk("err_idle", {font_cs, fb_valid, busy, cmd_ready}, 32'd1);
                if (n == 6) break;
            end else begin
                chk("font_we", 32'(font_we), 32'd0);
                chk("no_err", 32'(err), 32'd0);
                if (font_cs) begin
                    chk("font_addr", font_addr, {20'hE0001, rc, 4'(fetches), 1'b0});
                    if (v.mode == 0) chk("fetch_cycle", 32'(n), 32'(1 + 18 * fetches));
                    fetches++;
                end
                if (fb_valid) begin
                    if (q.size() == 0) begin
                        chk("extra_pix", 32'(fb_valid), 32'd0);
                    end else begin
                        chk("pix_x", 32'(fb_x), 32'(q[0].x));
                        chk("pix_y", 32'(fb_y), 32'(q[0].y));
                        chk("pix_data", 32'(fb_data), 32'(q[0].d));
                        if (fb_ready) begin
                            void'(q.pop_front());
                            writes++;
                        end else begin
                            stalls++;
                        end
                    end
                end
                if (done) done_n = n;
                else      chk("busy_flags", {busy, cmd_ready}, 32'd2);
            end
            @(posedge clk);
        end

        if (!bad && !aborted) begin
            chk("done_cycle", 32'(done_n), 32'(217 + stalls));
            chk("fetches", 32'(fetches), 32'd12);
            chk("pix_left", 32'(q.size()), 32'd0);
            if (v.exp_writes >= 0) chk("writes", 32'(writes), 32'(v.exp_writes));
            @(negedge clk);
            chk("post_idle", {done, busy, cmd_ready, fb_valid}, 32'd2);
        end
    endtask

    vec_t tbl[8];

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_char  = 7'd0;
        cmd_x     = 5'd0;
        cmd_y     = 4'd0;
        cmd_fg    = 16'd0;
        cmd_bg    = 16'd0;
        fb_ready  = 1'b0;

        tbl[0] = '{7'h31, 5'd0,  4'd0,  16'hFFFF, 16'h0000, 0, 0,   W_ONE};
        tbl[1] = '{7'h31, 5'd25, 4'd14, 16'hFFFF, 16'h0000, 0, 0,   W_ONE};
        tbl[2] = '{7'h41, 5'd26, 4'd0,  16'h1111, 16'h2222, 0, 0,   -1};
        tbl[3] = '{7'h05, 5'd3,  4'd2,  16'h1234, 16'hABCD, 0, 0,   W_BLANK};
        tbl[4] = '{7'h47, 5'd10, 4'd7,  16'hF00F, 16'h0FF0, 1, 0,   -1};
        tbl[5] = '{7'h31, 5'd2,  4'd3,  16'hFFFF, 16'h0000, 0, 115, -1};
        tbl[6] = '{7'h31, 5'd0,  4'd15, 16'hFFFF, 16'h0000, 0, 0,   -1};
        tbl[7] = '{7'h7F, 5'd24, 4'd13, 16'h5A5A, 16'hA5A5, 2, 0,   -1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_ctl", {busy, done, err, font_cs, font_we, fb_valid}, 32'd0);
        chk("rst_addr", font_addr, 32'd0);
        chk("rst_fb", {fb_x, fb_y, fb_data}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_case(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v.ch         = 7'($urandom);
            v.x          = 5'($urandom_range(0, 27));
            v.y          = 4'($urandom_range(0, 15));
            v.fg         = 16'($urandom);
            v.bg         = 16'($urandom);
            v.mode       = $urandom_range(0, 2);
            v.abort_at   = 0;
            v.exp_writes = -1;
            run_case(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
